// File: rtl/rv32_pkg.sv
// Shared integer-core constants: register file geometry and writeback source ids.
package rv32_pkg;
  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_AW     = 5;
  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_LSU = 1;
endpackage

// File: rtl/regfile_wb_scoreboard_rr_arb2.sv
// Two-requester round-robin arbiter; pointer names the side that wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic ptr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
  end

  // After a grant, priority moves to the side that lost.
  always_ff @(posedge clk) begin
    if (rst)         ptr <= 1'b0;
    else if (gnt[0]) ptr <= 1'b1;
    else if (gnt[1]) ptr <= 1'b0;
  end
endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Register-file write port owner: arbitrates ALU/LSU writebacks, tracks busy regs, stalls issue on hazards.
module regfile_wb_scoreboard #(
  parameter int XLEN = rv32_pkg::XLEN,
  parameter int NREG = rv32_pkg::NREG,
  parameter int AW   = rv32_pkg::REG_AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic            issue_rs1_e,
  input  logic [AW-1:0]   issue_rs1,
  input  logic            issue_rs2_e,
  input  logic [AW-1:0]   issue_rs2,
  input  logic            issue_rd_e,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic            wb0_valid,
  input  logic [AW-1:0]   wb0_rd,
  input  logic [XLEN-1:0] wb0_data,
  output logic            wb0_ready,
  input  logic            wb1_valid,
  input  logic [AW-1:0]   wb1_rd,
  input  logic [XLEN-1:0] wb1_data,
  output logic            wb1_ready,
  output logic            rd_e,
  output logic [AW-1:0]   rd,
  output logic [XLEN-1:0] rd_v,
  output logic [NREG-1:0] busy_vec,
  output logic            wb_err
);
  import rv32_pkg::*;

  logic [1:0]      req, gnt;
  logic            grant, wr_go, issue_fire;
  logic [AW-1:0]   g_rd;
  logic [XLEN-1:0] g_data;
  logic [NREG-1:0] busy_q, busy_nxt;

  assign req[WB_SRC_ALU] = wb0_valid;
  assign req[WB_SRC_LSU] = wb1_valid;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign wb0_ready = gnt[WB_SRC_ALU];
  assign wb1_ready = gnt[WB_SRC_LSU];

  always_comb begin
    grant  = |gnt;
    g_rd   = gnt[WB_SRC_LSU] ? wb1_rd   : wb0_rd;
    g_data = gnt[WB_SRC_LSU] ? wb1_data : wb0_data;
  end

  // A grant to x0 is consumed without producing a register-file write.
  assign wr_go = grant && (g_rd != '0);

  assign issue_ready = !(issue_rs1_e && busy_q[issue_rs1]) &&
                       !(issue_rs2_e && busy_q[issue_rs2]) &&
                       !(issue_rd_e  && busy_q[issue_rd]);
  assign issue_fire  = issue_valid && issue_ready;

  // Clear before set so a coinciding set for the same index wins.
  always_comb begin
    busy_nxt = busy_q;
    if (rd_e) busy_nxt[rd] = 1'b0;
    if (issue_fire && issue_rd_e && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      rd_e   <= 1'b0;
      rd     <= '0;
      rd_v   <= '0;
      wb_err <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      rd_e   <= wr_go;
      if (wr_go) begin
        rd   <= g_rd;
        rd_v <= g_data;
      end
      if (wr_go && !busy_q[g_rd]) wb_err <= 1'b1;
    end
  end

  assign busy_vec = busy_q;
endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Directed checks of arbitration, busy tracking, hazard stall, x0 handling, wb_err and reset.
module tb_regfile_wb_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_rs1_e, issue_rs2_e, issue_rd_e;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_ready;
  logic        wb0_valid, wb1_valid, wb0_ready, wb1_ready;
  logic [4:0]  wb0_rd, wb1_rd;
  logic [31:0] wb0_data, wb1_data;
  logic        rd_e, wb_err;
  logic [4:0]  rd;
  logic [31:0] rd_v, busy_vec;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  regfile_wb_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs1_e(issue_rs1_e), .issue_rs1(issue_rs1),
    .issue_rs2_e(issue_rs2_e), .issue_rs2(issue_rs2), .issue_rd_e(issue_rd_e),
    .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .rd_e(rd_e), .rd(rd), .rd_v(rd_v), .busy_vec(busy_vec), .wb_err(wb_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_rs1_e = 0; issue_rs2_e = 0; issue_rd_e = 0;
    issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    wb0_valid = 0; wb0_rd = 0; wb0_data = 0;
    wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
  endtask

  task automatic issue_dst(input logic [4:0] r);
    issue_valid = 1; issue_rd_e = 1; issue_rd = r;
    step();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    step(); step();
    rst = 0;
    #1;
    chk("rst_busy", busy_vec, 0);
    chk("rst_rd_e", {31'b0, rd_e}, 0);
    chk("rst_rd_v", rd_v, 0);
    chk("rst_err", {31'b0, wb_err}, 0);
    chk("rst_ready", {31'b0, issue_ready}, 1);
    chk("rst_gnt", {30'b0, wb1_ready, wb0_ready}, 0);

    // Both requesters continuously valid: alternate starting with wb0.
    wb0_valid = 1; wb0_rd = 5'd1; wb0_data = 32'hA0;
    wb1_valid = 1; wb1_rd = 5'd2; wb1_data = 32'hB1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_gnt%0d", i), {30'b0, wb1_ready, wb0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      step();
      chk($sformatf("rr_rde%0d", i), {31'b0, rd_e}, 1);
      chk($sformatf("rr_rd%0d", i), {27'b0, rd}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("rr_rdv%0d", i), rd_v, (i % 2 == 0) ? 32'hA0 : 32'hB1);
    end
    idle_inputs();
    #1;
    chk("rr_idle_gnt", {30'b0, wb1_ready, wb0_ready}, 0);
    step();
    chk("rr_idle_rde", {31'b0, rd_e}, 0);
    chk("rr_err", {31'b0, wb_err}, 1);
    rst = 1; step(); rst = 0; #1;
    chk("rr_rst_err", {31'b0, wb_err}, 0);

    // RAW on x5: stall until the cycle after its writeback lands.
    issue_valid = 1; issue_rd_e = 1; issue_rd = 5'd5;
    #1;
    chk("x5_ready", {31'b0, issue_ready}, 1);
    step();
    idle_inputs();
    chk("x5_busy", busy_vec, 32'h20);
    issue_valid = 1; issue_rs1_e = 1; issue_rs1 = 5'd5;
    #1;
    chk("x5_raw", {31'b0, issue_ready}, 0);
    issue_rs1_e = 0; issue_rs2_e = 1; issue_rs2 = 5'd5;
    #1;
    chk("x5_raw2", {31'b0, issue_ready}, 0);
    issue_rs2_e = 0; issue_rd_e = 1; issue_rd = 5'd5;
    #1;
    chk("x5_waw", {31'b0, issue_ready}, 0);
    issue_rd_e = 0;
    #1;
    chk("x5_noen", {31'b0, issue_ready}, 1);
    issue_rs1_e = 1;
    wb1_valid = 1; wb1_rd = 5'd5; wb1_data = 32'h55;
    #1;
    chk("x5_wb1gnt", {30'b0, wb1_ready, wb0_ready}, 2);
    step();
    wb1_valid = 0;
    chk("x5_rde", {31'b0, rd_e}, 1);
    chk("x5_rdv", rd_v, 32'h55);
    chk("x5_nobypass", {31'b0, issue_ready}, 0);
    step();
    chk("x5_clr", busy_vec, 0);
    chk("x5_go", {31'b0, issue_ready}, 1);
    chk("x5_err", {31'b0, wb_err}, 0);
    idle_inputs();

    // x3 writeback: one-cycle write latency, busy clears on the write edge.
    issue_dst(5'd3);
    wb0_valid = 1; wb0_rd = 5'd3; wb0_data = 32'hDEADBEEF;
    #1;
    chk("x3_gnt", {30'b0, wb1_ready, wb0_ready}, 1);
    step();
    wb0_valid = 0;
    chk("x3_rde", {31'b0, rd_e}, 1);
    chk("x3_rd", {27'b0, rd}, 3);
    chk("x3_rdv", rd_v, 32'hDEADBEEF);
    chk("x3_busy", busy_vec, 32'h8);
    step();
    chk("x3_clr", busy_vec, 0);
    chk("x3_rde0", {31'b0, rd_e}, 0);
    chk("x3_hold_rd", {27'b0, rd}, 3);
    chk("x3_hold_rdv", rd_v, 32'hDEADBEEF);

    // x0 writeback is swallowed.
    issue_dst(5'd9);
    wb1_valid = 1; wb1_rd = 5'd0; wb1_data = 32'h1234;
    #1;
    chk("x0_gnt", {30'b0, wb1_ready, wb0_ready}, 2);
    step();
    wb1_valid = 0;
    chk("x0_rde", {31'b0, rd_e}, 0);
    chk("x0_busy", busy_vec, 32'h200);
    chk("x0_err", {31'b0, wb_err}, 0);

    // Reset with x9 busy and a grant in flight.
    issue_valid = 1; issue_rd_e = 1; issue_rd = 5'd9;
    wb0_valid = 1; wb0_rd = 5'd9; wb0_data = 32'h99;
    rst = 1;
    step();
    rst = 0;
    wb0_valid = 0;
    #1;
    chk("mrst_busy", busy_vec, 0);
    chk("mrst_rde", {31'b0, rd_e}, 0);
    chk("mrst_rdv", rd_v, 0);
    chk("mrst_err", {31'b0, wb_err}, 0);
    chk("mrst_ready", {31'b0, issue_ready}, 1);
    idle_inputs();

    // Writeback to a non-busy register: error is sticky, write still happens.
    wb0_valid = 1; wb0_rd = 5'd7; wb0_data = 32'h77;
    step();
    wb0_valid = 0;
    chk("err_set", {31'b0, wb_err}, 1);
    chk("err_rde", {31'b0, rd_e}, 1);
    chk("err_rd", {27'b0, rd}, 7);
    step(); step(); step();
    chk("err_sticky", {31'b0, wb_err}, 1);
    chk("err_busy", busy_vec, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
